// File: rtl/ray_column_buffer_if.sv
//------------------------------------------------------------------------------
// Module      : ray_column_buffer_if
// Description : Producer write handshake, vsync and display read bus for the
//               ray column double buffer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ray_column_buffer_if #(
  parameter int DW = 32
);
  logic          wr_valid;
  logic          wr_ready;
  logic [9:0]    wr_col;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          vs;
  logic [9:0]    rd_col;
  logic [DW-1:0] rd_data;
  logic          front_valid;
  logic [7:0]    stale_count;

  modport master (
    output wr_valid, wr_col, wr_data, wr_last, vs, rd_col,
    input  wr_ready, rd_data, front_valid, stale_count
  );

  modport slave (
    input  wr_valid, wr_col, wr_data, wr_last, vs, rd_col,
    output wr_ready, rd_data, front_valid, stale_count
  );
endinterface

`default_nettype wire

// File: rtl/ray_column_buffer.sv
//------------------------------------------------------------------------------
// Module      : ray_column_buffer
// Description : Double-buffered column store; banks swap on vsync falling edge
//               only when a full frame is waiting. RAY_BUF_CLEAR_EN zeroes
//               the new back bank after every swap.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ray_column_buffer #(
  parameter int COLS = 640,
  parameter int DW   = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  ray_column_buffer_if.slave   bus
);

  localparam logic [10:0] c_cols = 11'(COLS);
`ifdef RAY_BUF_CLEAR_EN
  localparam logic [9:0]  c_last_col = 10'(COLS - 1);
`endif

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_FULL  = 2'd1
`ifdef RAY_BUF_CLEAR_EN
    ,
    S_CLEAR = 2'd2
`endif
  } state_t;

  logic [DW-1:0] r_bank [2][COLS];

  state_t        r_state;
  logic          r_front_sel;
  logic          r_vs_q;
  logic          r_front_valid;
  logic [7:0]    r_stale;
  logic [DW-1:0] r_rd_data;
  logic          r_ready;
`ifdef RAY_BUF_CLEAR_EN
  logic [9:0]    r_clr_col;
`endif

  logic          w_wr_ready;
  logic          w_accept;
  logic          w_edge;
  logic          w_wr_col_ok;
  logic          w_rd_col_ok;
  logic          w_mem_we;
  logic [9:0]    w_mem_addr;
  logic [DW-1:0] w_mem_data;

  // Ready is masked by reset so the producer sees 0 for the whole reset window.
  assign w_wr_ready  = r_ready & ~RESET;
  assign w_accept    = bus.wr_valid & w_wr_ready;
  assign w_edge      = r_vs_q & ~bus.vs;
  assign w_wr_col_ok = {1'b0, bus.wr_col} < c_cols;
  assign w_rd_col_ok = {1'b0, bus.rd_col} < c_cols;

  always_comb begin
    w_mem_we   = w_accept & w_wr_col_ok;
    w_mem_addr = bus.wr_col;
    w_mem_data = bus.wr_data;
`ifdef RAY_BUF_CLEAR_EN
    if (r_state == S_CLEAR && !RESET) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_clr_col;
      w_mem_data = '0;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      r_bank[~r_front_sel][w_mem_addr] <= w_mem_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state       <= S_FILL;
      r_front_sel   <= 1'b0;
      r_vs_q        <= 1'b1;
      r_front_valid <= 1'b0;
      r_stale       <= 8'd0;
      r_rd_data     <= '0;
      r_ready       <= 1'b1;
`ifdef RAY_BUF_CLEAR_EN
      r_clr_col     <= 10'd0;
`endif
    end else begin
      r_vs_q    <= bus.vs;
      r_rd_data <= (r_front_valid && w_rd_col_ok) ? r_bank[r_front_sel][bus.rd_col] : '0;

      // Any edge that does not find a waiting frame is a skipped frame.
      if (w_edge && r_state != S_FULL && r_stale != 8'hFF) begin
        r_stale <= r_stale + 8'd1;
      end

      case (r_state)
        S_FILL: begin
          if (w_accept && bus.wr_last) begin
            r_state <= S_FULL;
            r_ready <= 1'b0;
          end
        end
        S_FULL: begin
          if (w_edge) begin
            r_front_sel   <= ~r_front_sel;
            r_front_valid <= 1'b1;
`ifdef RAY_BUF_CLEAR_EN
            r_state       <= S_CLEAR;
            r_clr_col     <= 10'd0;
`else
            r_state       <= S_FILL;
            r_ready       <= 1'b1;
`endif
          end
        end
`ifdef RAY_BUF_CLEAR_EN
        S_CLEAR: begin
          if (r_clr_col == c_last_col) begin
            r_state <= S_FILL;
            r_ready <= 1'b1;
          end else begin
            r_clr_col <= r_clr_col + 10'd1;
          end
        end
`endif
        default: begin
          r_state <= S_FILL;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.wr_ready    = w_wr_ready;
  assign bus.rd_data     = r_rd_data;
  assign bus.front_valid = r_front_valid;
  assign bus.stale_count = r_stale;

endmodule

`default_nettype wire

// File: tb/tb_ray_column_buffer.sv
//------------------------------------------------------------------------------
// Module      : tb_ray_column_buffer
// Description : Self-checking bench for ray_column_buffer; read results are
//               predicted into a queue and compared one cycle later.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ray_column_buffer;

  localparam int COLS = 640;
  localparam int DW   = 32;
`ifdef RAY_BUF_CLEAR_EN
  localparam bit c_clear = 1'b1;
`else
  localparam bit c_clear = 1'b0;
`endif

  typedef struct {
    string         tag;
    logic [DW-1:0] exp;
  } sb_item_t;

  logic CLK;
  logic RESET;
  int   n_checks = 0;
  int   n_pass   = 0;
  sb_item_t sb_q[$];
  bit   sb_armed = 1'b0;

  ray_column_buffer_if #(.DW(DW)) bus ();

  ray_column_buffer #(.COLS(COLS), .DW(DW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    sb_item_t it;
    @(posedge CLK);
    #1;
    if (sb_armed) begin
      sb_armed = 1'b0;
      it = sb_q.pop_front();
      check(it.tag, bus.rd_data, it.exp);
    end
  endtask

  task automatic read_expect(input logic [9:0] col, input logic [31:0] exp);
    sb_item_t it;
    bus.rd_col = col;
    it.tag = $sformatf("rd[%0d]", col);
    it.exp = exp;
    sb_q.push_back(it);
    sb_armed = 1'b1;
  endtask

  task automatic write_rec(input logic [9:0] col, input logic [31:0] d,
                           input bit last, input bit collide);
    int waited = 0;
    while (!bus.wr_ready && waited < 2000) begin
      tick();
      waited++;
    end
    if (!bus.wr_ready) check("wr_ready_wait", {31'd0, bus.wr_ready}, 32'd1);
    bus.wr_valid = 1'b1;
    bus.wr_col   = col;
    bus.wr_data  = d;
    bus.wr_last  = last;
    if (collide) bus.vs = 1'b0;
    tick();
    bus.wr_valid = 1'b0;
    bus.wr_last  = 1'b0;
    bus.vs       = 1'b1;
  endtask

  task automatic write_range(input int first, input int last_col,
                             input logic [31:0] base, input bit set_last);
    for (int c = first; c <= last_col; c++)
      write_rec(10'(c), base + 32'(c), set_last && (c == last_col), 1'b0);
  endtask

  // Returns front_valid and wr_ready as seen in the cycle after the edge cycle.
  task automatic vs_pulse(output logic fv, output logic rdy);
    bus.vs = 1'b0;
    tick();
    fv  = bus.front_valid;
    rdy = bus.wr_ready;
    bus.vs = 1'b1;
    tick();
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic fv, rdy;
    int   cnt;

    RESET        = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_col   = '0;
    bus.wr_data  = '0;
    bus.wr_last  = 1'b0;
    bus.vs       = 1'b1;
    bus.rd_col   = '0;

    // Reset state and read sweep of an unswapped buffer
    repeat (3) tick();
    check("ready_in_reset", {31'd0, bus.wr_ready}, 32'd0);
    RESET = 1'b0;
    #1;
    check("ready_after_reset", {31'd0, bus.wr_ready}, 32'd1);
    check("front_valid_reset", {31'd0, bus.front_valid}, 32'd0);
    check("stale_reset", {24'd0, bus.stale_count}, 32'd0);
    check("rd_data_reset", bus.rd_data, 32'd0);
    for (int c = 0; c < COLS; c++) begin
      read_expect(10'(c), 32'd0);
      tick();
    end

    // Frame A: col*3, with an out-of-range record first
    write_rec(10'd700, 32'hDEAD_BEEF, 1'b0, 1'b0);
    for (int c = 0; c < COLS; c++)
      write_rec(10'(c), 32'(c * 3), c == COLS - 1, 1'b0);
    check("ready_after_last", {31'd0, bus.wr_ready}, 32'd0);
    tick();
    check("ready_full_hold", {31'd0, bus.wr_ready}, 32'd0);
    check("front_valid_pre_swap", {31'd0, bus.front_valid}, 32'd0);
    vs_pulse(fv, rdy);
    check("front_valid_swap1", {31'd0, fv}, 32'd1);
    check("ready_n1_swap1", {31'd0, rdy}, c_clear ? 32'd0 : 32'd1);
    cnt = 0;
    while (!bus.wr_ready && cnt < 2000) begin
      tick();
      cnt++;
    end
    check("ready_delay_swap1", 32'(cnt), c_clear ? 32'(COLS - 1) : 32'd0);
    check("stale_after_swap1", {24'd0, bus.stale_count}, 32'd0);
    read_expect(10'd100, 32'd300);   tick();
    read_expect(10'd639, 32'd1917);  tick();
    read_expect(10'd0,   32'd0);     tick();
    read_expect(10'd650, 32'd0);     tick();

    // Frame B while the display reads column 5 continuously
    for (int c = 0; c < COLS; c++) begin
      read_expect(10'd5, 32'd15);
      write_rec(10'(c), 32'hA5A5_0000 + 32'(c), c == COLS - 1, 1'b0);
    end
    read_expect(10'd5, 32'd15);
    vs_pulse(fv, rdy);
    read_expect(10'd5, 32'hA5A5_0005);  tick();
    read_expect(10'd639, 32'hA5A5_027F); tick();

    // Late frame: edge after 200 records does not swap
    write_range(0, 199, 32'h1100_0000, 1'b0);
    vs_pulse(fv, rdy);
    check("stale_late", {24'd0, bus.stale_count}, 32'd1);
    check("ready_late_fill", {31'd0, bus.wr_ready}, 32'd1);
    read_expect(10'd5, 32'hA5A5_0005); tick();
    write_range(200, COLS - 1, 32'h1100_0000, 1'b1);
    vs_pulse(fv, rdy);
    check("stale_after_late_swap", {24'd0, bus.stale_count}, 32'd1);
    read_expect(10'd5,   32'h1100_0005); tick();
    read_expect(10'd639, 32'h1100_027F); tick();

    // Collision: wr_last accepted in the same cycle as the vsync edge
    write_range(0, COLS - 2, 32'h2200_0000, 1'b0);
    write_rec(10'(COLS - 1), 32'h2200_0000 + 32'(COLS - 1), 1'b1, 1'b1);
    check("stale_collision", {24'd0, bus.stale_count}, 32'd2);
    check("ready_collision", {31'd0, bus.wr_ready}, 32'd0);
    read_expect(10'd5, 32'h1100_0005); tick();
    vs_pulse(fv, rdy);
    check("stale_after_collision_swap", {24'd0, bus.stale_count}, 32'd2);
    read_expect(10'd639, 32'h2200_027F); tick();
    read_expect(10'd5,   32'h2200_0005); tick();

    // Stale counter saturation
    for (int i = 0; i < 100; i++) vs_pulse(fv, rdy);
    check("stale_102", {24'd0, bus.stale_count}, 32'd102);
    for (int i = 0; i < 200; i++) vs_pulse(fv, rdy);
    check("stale_saturated", {24'd0, bus.stale_count}, 32'd255);
    read_expect(10'd5, 32'h2200_0005); tick();

    // Reset mid-frame abandons the partial frame
    write_range(0, 49, 32'h4400_0000, 1'b0);
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    #1;
    check("front_valid_rereset", {31'd0, bus.front_valid}, 32'd0);
    check("stale_rereset", {24'd0, bus.stale_count}, 32'd0);
    check("ready_rereset", {31'd0, bus.wr_ready}, 32'd1);
    read_expect(10'd5, 32'd0); tick();
    write_range(0, COLS - 1, 32'h3300_0000, 1'b1);
    vs_pulse(fv, rdy);
    check("front_valid_swap_rereset", {31'd0, fv}, 32'd1);
    read_expect(10'd5,  32'h3300_0005); tick();
    read_expect(10'd60, 32'h3300_003C); tick();

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ray_column_buffer.md
# ray_column_buffer

Double-buffered column store between the raycasting stage (producer, one 32-bit record per screen column) and the colour mapping stage (consumer, reads by `vga_x`). The producer fills a back bank at its own pace while the display reads a stable front bank. Banks swap only at the start of vertical sync, and only when a complete frame is waiting. This removes mid-frame tearing from the single-port ray RAM path.

## Interface
Parameters:
- `COLS`, 640, number of columns per frame; valid column indices are 0..COLS-1.
- `DW`, 32, width of one column record.

Ports:
- `CLK` in 1: system clock (50 MHz), the only clock.
- `RESET` in 1: synchronous, active-high reset.
- `wr_valid` in 1: producer has a column record.
- `wr_ready` out 1: buffer accepts a record this cycle.
- `wr_col` in 10: destination column of the record.
- `wr_data` in DW: column record.
- `wr_last` in 1: qualifies an accepted record as the final one of the frame.
- `vs` in 1: active-low vertical sync from the VGA controller.
- `rd_col` in 10: display column (`vga_x`).
- `rd_data` out DW: front-bank record for `rd_col`, registered.
- `front_valid` out 1: at least one swap has occurred since reset.
- `stale_count` out 8: saturating count of vsync edges that found no complete frame.

## Operation
- Storage: two banks of COLS×DW. `front_sel` chooses the read bank; the write bank is `~front_sel`.
- Write accept: accepted when `wr_valid & wr_ready`.
  - `wr_col < COLS`: write `wr_data` to the back bank.
  - `wr_col >= COLS`: the record is accepted and discarded.
- States:
  - FILL: `wr_ready`=1. An accepted record with `wr_last` set moves to FULL.
  - FULL: `wr_ready`=0. Waits for a vsync edge.
  - CLEAR: only when `RAY_BUF_CLEAR_EN` is defined; see Configuration.
- Vsync edge: `vs_q` is `vs` registered one cycle. Edge = `vs_q & ~vs` (falling edge).
  - Edge in FULL: toggle `front_sel`, set `front_valid`, go to FILL (or CLEAR).
  - Edge in FILL: no swap; `stale_count` += 1, saturating at 255. Partial back-bank contents are kept and the producer continues.
- Simultaneous edge and accepted `wr_last` (state FILL): the record is written and the state goes to FULL. No swap this cycle. `stale_count` increments. The swap happens on the next edge.
- Read path:
  - `rd_data` <= (`front_valid` & `rd_col < COLS`) ? front[`rd_col`] : 0.
  - Reads never stall and never affect the state machine.
- Reset (reset values):
  - `front_sel`=0, state FILL, `vs_q`=1, `front_valid`=0, `stale_count`=0, `rd_data`=0.
  - `wr_ready`=0 while `RESET` is high and 1 on the first cycle after it deasserts.
  - Bank contents are not reset.
- Reset mid-frame: any partial frame is abandoned and the write bank becomes bank 1 again.

## Timing
- Read latency is 1 cycle: `rd_col` presented at edge N gives `rd_data` valid after edge N+1.
- Swap, with the edge detected in cycle N:
  - `front_sel` flips at the end of cycle N.
  - Reads addressed in cycle N+1 return the new front bank.
  - `wr_ready` rises in cycle N+1 (no clear) or in cycle N+1+COLS (clear).
- `wr_ready` falls in the cycle after the `wr_last` accept, so at most one record is accepted per cycle and none after `wr_last`.
- Throughput in FILL is 1 record/cycle.
- Swap-to-swap minimum is one vsync period; the producer must finish COLS records within one frame or frames are skipped (reported via `stale_count`).

## Configuration
- `RAY_BUF_CLEAR_EN` defined:
  - After each swap, state CLEAR writes 0 to every column of the new back bank, one column per cycle (COLS cycles), with `wr_ready`=0.
  - Then the state goes to FILL.
  - An edge during CLEAR increments `stale_count`.
  - Columns the producer skips therefore read as 0.
- `RAY_BUF_CLEAR_EN` undefined: no CLEAR state. Skipped columns keep the data from two frames earlier.

## Test plan
- Reset then read: hold `RESET` 3 cycles, sweep `rd_col` 0..639 -> `rd_data`=0 throughout; `front_valid`=0, `stale_count`=0, `wr_ready`=1 on the first post-reset cycle.
- Fill and swap: write `wr_data`=col×3 for cols 0..639, `wr_last` on 639, pulse `vs` low -> `wr_ready`=0 after col 639; after the edge, `front_valid`=1; reading col 100 returns 300 with 1-cycle latency; `wr_ready`=1 in the next cycle (640 cycles later with `RAY_BUF_CLEAR_EN`).
- Tear-free: after one swap, write a second frame with data `0xA5A5_0000`+col while reading col 5 continuously -> `rd_data` stays 15 until the next vsync edge, then becomes `0xA5A5_0005`.
- Late frame: vsync edge after only 200 records -> no swap, `stale_count`=1; finish the remaining records with `wr_last`, next edge -> swap.
- Collision: `wr_last` accept in the same cycle as the vsync edge -> no swap, `stale_count` increments, state FULL; the swap occurs on the following edge.
- Bounds and saturation: `wr_col`=700 is accepted without writing to any column; `rd_col`=650 -> `rd_data`=0; 300 edges with no frame -> `stale_count`=255.
